// File: rtl/conv2d_stage_pkg.sv
// Shared types, default geometry and saturating add for the conv bias/activation stage.
// Optional ReLU is selected with the CONV_BIAS_ACT_RELU_EN macro (see conv2d_lane_sat).
package conv2d_stage_pkg;

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_OUT_HEIGHT = 3;
    localparam int DEF_OUT_WIDTH  = 2;
    localparam int DEF_FILTERS    = 8;
    localparam int DEF_WORD_WIDTH = 8;
    localparam int DEF_LANES      = 2;

    localparam int GROUPS          = DEF_FILTERS / DEF_LANES;
    localparam int PIXELS          = DEF_OUT_HEIGHT * DEF_OUT_WIDTH;
    localparam int BEATS_PER_FRAME = PIXELS * GROUPS;

    // Adds two already sign-extended words and clamps to the signed range of 'width' bits.
    function automatic int sat_add(input int a, input int b, input int width);
        int sum;
        int hi;
        int lo;
        sum = a + b;
        hi  = (1 << (width - 1)) - 1;
        lo  = -(1 << (width - 1));
        if (sum > hi) begin
            sum = hi;
        end else if (sum < lo) begin
            sum = lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/conv2d_lane_sat.sv
// One lane of the stage: signed add of bias, clamp to WORD_WIDTH, optional ReLU.
// Define CONV_BIAS_ACT_RELU_EN to force negative results to zero.
module conv2d_lane_sat
    import conv2d_stage_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
    input  logic signed [WORD_WIDTH-1:0] data_i,
    input  logic signed [WORD_WIDTH-1:0] bias_i,
    output logic        [WORD_WIDTH-1:0] result_o
);

    int clamped;

    always_comb begin
        clamped = sat_add(int'(data_i), int'(bias_i), WORD_WIDTH);
`ifdef CONV_BIAS_ACT_RELU_EN
        if (clamped < 0) begin
            clamped = 0;
        end
`else
        clamped = clamped;
`endif
        result_o = WORD_WIDTH'(clamped);
    end

endmodule

// File: rtl/conv2d_bias_act_stage.sv
// Bias/saturate/activate stage behind the 3x3 conv core; re-emits AXI-Stream with per-frame tlast.
// Optional ReLU via CONV_BIAS_ACT_RELU_EN (implemented inside conv2d_lane_sat).
module conv2d_bias_act_stage
    import conv2d_stage_pkg::*;
#(
    parameter int OUT_HEIGHT = DEF_OUT_HEIGHT,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
    parameter int FILTERS    = DEF_FILTERS,
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int LANES      = DEF_LANES
) (
    input  logic                        i_aclk,
    input  logic                        i_areset,
    input  logic                        i_bias_tvalid,
    output logic                        o_bias_tready,
    input  logic [WORD_WIDTH-1:0]       i_bias_tdata,
    input  logic                        i_tvalid,
    output logic                        o_tready,
    input  logic [LANES*WORD_WIDTH-1:0] i_tdata,
    input  logic                        i_tready,
    output logic                        o_tvalid,
    output logic [LANES*WORD_WIDTH-1:0] o_tdata,
    output logic                        o_tlast,
    output logic                        o_frame_done
);

    localparam int NUM_GROUPS = FILTERS / LANES;
    localparam int NUM_PIXELS = OUT_HEIGHT * OUT_WIDTH;
    localparam int DATA_W     = LANES * WORD_WIDTH;
    localparam int IDX_W      = (FILTERS > 1) ? $clog2(FILTERS) : 1;
    localparam int GRP_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam int PIX_W      = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  biasIdx_q, biasIdx_d;
    logic [GRP_W-1:0]  grp_q, grp_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic [WORD_WIDTH-1:0] bias_q [FILTERS];

    logic              s1Valid_q;
    logic [DATA_W-1:0] s1Data_q;
    logic              s1Last_q;
    logic              outValid_q;
    logic [DATA_W-1:0] outData_q;
    logic              outLast_q;
    logic              frameDone_q;

    logic              biasFire;
    logic              inFire;
    logic              outReady;
    logic              s1Advance;
    logic              grpAtMax;
    logic              pixAtMax;
    logic              lastTag;
    logic [DATA_W-1:0] laneResult;

    assign o_bias_tready = (state_q == LOAD);
    assign biasFire      = i_bias_tvalid && o_bias_tready;
    assign outReady      = !outValid_q || i_tready;
    assign s1Advance     = s1Valid_q && outReady;
    assign o_tready      = (state_q == RUN) && (!s1Valid_q || outReady);
    assign inFire        = i_tvalid && o_tready;
    assign grpAtMax      = (grp_q == GRP_W'(NUM_GROUPS - 1));
    assign pixAtMax      = (pix_q == PIX_W'(NUM_PIXELS - 1));
    assign lastTag       = grpAtMax && pixAtMax;

    assign o_tvalid     = outValid_q;
    assign o_tdata      = outData_q;
    assign o_tlast      = outLast_q;
    assign o_frame_done = frameDone_q;

    always_comb begin
        state_d = state_q;
        if (state_q == LOAD && biasFire && biasIdx_q == IDX_W'(FILTERS - 1)) begin
            state_d = RUN;
        end
    end

    // Group selects the bias slice; pixel advances when the group wraps, both wrap together at frame end.
    always_comb begin
        biasIdx_d = biasIdx_q;
        grp_d     = grp_q;
        pix_d     = pix_q;
        if (biasFire) begin
            biasIdx_d = (biasIdx_q == IDX_W'(FILTERS - 1)) ? '0 : biasIdx_q + 1'b1;
        end
        if (inFire) begin
            if (grpAtMax) begin
                grp_d = '0;
                pix_d = pixAtMax ? '0 : pix_q + 1'b1;
            end else begin
                grp_d = grp_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            state_q   <= LOAD;
            biasIdx_q <= '0;
            grp_q     <= '0;
            pix_q     <= '0;
            for (int i = 0; i < FILTERS; i++) begin
                bias_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            biasIdx_q <= biasIdx_d;
            grp_q     <= grp_d;
            pix_q     <= pix_d;
            if (biasFire) begin
                bias_q[biasIdx_q] <= i_bias_tdata;
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [IDX_W-1:0] biasSel;
        assign biasSel = IDX_W'(int'(grp_q) * LANES + k);

        conv2d_lane_sat #(
            .WORD_WIDTH (WORD_WIDTH)
        ) u_lane (
            .data_i   (i_tdata[k*WORD_WIDTH +: WORD_WIDTH]),
            .bias_i   (bias_q[biasSel]),
            .result_o (laneResult[k*WORD_WIDTH +: WORD_WIDTH])
        );
    end

    // Output register only reloads when empty or consumed, so data and tlast hold during a stall.
    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            s1Valid_q   <= 1'b0;
            s1Data_q    <= '0;
            s1Last_q    <= 1'b0;
            outValid_q  <= 1'b0;
            outData_q   <= '0;
            outLast_q   <= 1'b0;
            frameDone_q <= 1'b0;
        end else begin
            if (inFire) begin
                s1Valid_q <= 1'b1;
                s1Data_q  <= laneResult;
                s1Last_q  <= lastTag;
            end else if (s1Advance) begin
                s1Valid_q <= 1'b0;
            end
            if (outReady) begin
                outValid_q <= s1Valid_q;
                outData_q  <= s1Data_q;
                outLast_q  <= s1Valid_q && s1Last_q;
            end
            frameDone_q <= outValid_q && i_tready && outLast_q;
        end
    end

endmodule

// File: tb/tb_conv2d_bias_act_stage.sv
// Directed bench for conv2d_bias_act_stage with a queue model; honours CONV_BIAS_ACT_RELU_EN.
module tb_conv2d_bias_act_stage;

    logic        i_aclk;
    logic        i_areset;
    logic        i_bias_tvalid;
    logic        o_bias_tready;
    logic [7:0]  i_bias_tdata;
    logic        i_tvalid;
    logic        o_tready;
    logic [15:0] i_tdata;
    logic        i_tready;
    logic        o_tvalid;
    logic [15:0] o_tdata;
    logic        o_tlast;
    logic        o_frame_done;

    int checkCount = 0;
    int errorCount = 0;

    logic [7:0]  expBias [8];
    logic [16:0] expQ [$];
    logic [15:0] outLog [$];
    logic        randomReady = 1'b0;
    int cycleCnt = 0;
    int inBeat, outBeat, tlastCnt, frameDoneCnt, lastIdx;
    int firstInCycle, firstOutCycle;
    logic stalled, heldLast, prevLastFire;
    logic [15:0] heldData;
    logic [15:0] expData;
    logic [16:0] entry;
    int grp;

    conv2d_bias_act_stage dut (
        .i_aclk        (i_aclk),
        .i_areset      (i_areset),
        .i_bias_tvalid (i_bias_tvalid),
        .o_bias_tready (o_bias_tready),
        .i_bias_tdata  (i_bias_tdata),
        .i_tvalid      (i_tvalid),
        .o_tready      (o_tready),
        .i_tdata       (i_tdata),
        .i_tready      (i_tready),
        .o_tvalid      (o_tvalid),
        .o_tdata       (o_tdata),
        .o_tlast       (o_tlast),
        .o_frame_done  (o_frame_done)
    );

    initial begin
        i_aclk = 1'b0;
        forever #5 i_aclk = ~i_aclk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    always @(posedge i_aclk) begin
        #1;
        i_tready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] expectLane(input logic [7:0] x, input logic [7:0] b);
        int s;
        s = int'($signed(x)) + int'($signed(b));
        if (s > 127) s = 127;
        if (s < -128) s = -128;
`ifdef CONV_BIAS_ACT_RELU_EN
        if (s < 0) s = 0;
`endif
        return 8'(s);
    endfunction

    // Reference model: predicts each accepted beat and checks outputs, stalls and frame_done.
    always @(posedge i_aclk) begin
        cycleCnt++;
        if (i_areset) begin
            expQ.delete();
            outLog.delete();
            inBeat = 0; outBeat = 0; tlastCnt = 0; frameDoneCnt = 0; lastIdx = -1;
            stalled = 1'b0; prevLastFire = 1'b0;
        end else begin
            if (o_frame_done || prevLastFire)
                checkOutput("frame_done", 32'(o_frame_done), 32'(prevLastFire));
            if (o_frame_done) frameDoneCnt++;
            if (stalled) begin
                checkOutput("stall_valid", 32'(o_tvalid), 32'd1);
                checkOutput("stall_data", 32'(o_tdata), 32'(heldData));
                checkOutput("stall_last", 32'(o_tlast), 32'(heldLast));
            end
            if (i_tvalid && o_tready) begin
                grp = inBeat % 4;
                expData = {expectLane(i_tdata[15:8], expBias[grp*2+1]),
                           expectLane(i_tdata[7:0], expBias[grp*2])};
                expQ.push_back({((inBeat % 24) == 23), expData});
                if (inBeat == 0) firstInCycle = cycleCnt;
                inBeat++;
            end
            if (o_tvalid && i_tready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    entry = expQ.pop_front();
                    checkOutput("out_data", 32'(o_tdata), 32'(entry[15:0]));
                    checkOutput("out_last", 32'(o_tlast), 32'(entry[16]));
                end
                outLog.push_back(o_tdata);
                if (o_tlast) begin
                    tlastCnt++;
                    lastIdx = outBeat;
                end
                if (outBeat == 0) firstOutCycle = cycleCnt;
                outBeat++;
            end
            stalled      = o_tvalid && !i_tready;
            heldData     = o_tdata;
            heldLast     = o_tlast;
            prevLastFire = o_tvalid && i_tready && o_tlast;
        end
    end

    task automatic doReset();
        i_areset = 1'b1;
        i_tvalid = 1'b0;
        i_bias_tvalid = 1'b0;
        randomReady = 1'b0;
        repeat (2) @(posedge i_aclk);
        #1;
        i_areset = 1'b0;
    endtask

    task automatic loadBiases();
        logic acc;
        for (int i = 0; i < 8; i++) begin
            i_bias_tvalid = 1'b1;
            i_bias_tdata = expBias[i];
            #1;
            acc = o_bias_tready;
            checkOutput("load_bias_ready", 32'(acc), 32'd1);
            checkOutput("load_tready", 32'(o_tready), 32'd0);
            @(posedge i_aclk);
            #1;
        end
        i_bias_tvalid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] l0, input logic [7:0] l1);
        logic acc;
        int waitCnt;
        acc = 1'b0;
        waitCnt = 0;
        i_tvalid = 1'b1;
        i_tdata = {l1, l0};
        while (!acc && waitCnt < 200) begin
            #1;
            acc = o_tready;
            @(posedge i_aclk);
            #1;
            waitCnt++;
        end
        if (!acc) checkOutput("in_timeout", 32'd0, 32'd1);
        i_tvalid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        randomReady = 1'b0;
        while (expQ.size() != 0 && n < 400) begin
            @(posedge i_aclk);
            #1;
            n++;
        end
        checkOutput("drain", 32'(expQ.size()), 32'd0);
        repeat (3) @(posedge i_aclk);
        #1;
    endtask

    logic [15:0] hand0, hand1, hand2;

    initial begin
        i_areset = 1'b1;
        i_bias_tvalid = 1'b0;
        i_bias_tdata = '0;
        i_tvalid = 1'b0;
        i_tdata = '0;

        $display("[TB] reset and bias load");
        doReset();
        checkOutput("rst_tvalid", 32'(o_tvalid), 32'd0);
        checkOutput("rst_tready", 32'(o_tready), 32'd0);
        checkOutput("rst_bias_tready", 32'(o_bias_tready), 32'd1);
        checkOutput("rst_tlast", 32'(o_tlast), 32'd0);
        checkOutput("rst_frame_done", 32'(o_frame_done), 32'd0);
        for (int i = 0; i < 8; i++) expBias[i] = 8'(i);
        i_tvalid = 1'b1;
        i_tdata = 16'h0101;
        loadBiases();
        checkOutput("run_bias_tready", 32'(o_bias_tready), 32'd0);
        checkOutput("run_tready", 32'(o_tready), 32'd1);
        i_tvalid = 1'b0;

        $display("[TB] bias beats ignored in RUN");
        i_bias_tvalid = 1'b1;
        i_bias_tdata = 8'd99;
        for (int i = 0; i < 3; i++) begin
            checkOutput("run_bias_ignored", 32'(o_bias_tready), 32'd0);
            @(posedge i_aclk);
            #1;
        end
        i_bias_tvalid = 1'b0;
        applyStimulus(8'd3, 8'hFD);
        waitDrain();
`ifdef CONV_BIAS_ACT_RELU_EN
        hand0 = 16'h0003;
`else
        hand0 = 16'hFE03;
`endif
        checkOutput("bias_kept", 32'(outLog.size() > 0 ? outLog[0] : 16'hDEAD), 32'(hand0));

        $display("[TB] zero bias frame");
        doReset();
        for (int i = 0; i < 8; i++) expBias[i] = 8'd0;
        loadBiases();
        for (int k = 0; k < 24; k++) applyStimulus(8'(k), 8'(k));
        waitDrain();
        checkOutput("f1_beats", 32'(outBeat), 32'd24);
        checkOutput("f1_latency", 32'(firstOutCycle - firstInCycle), 32'd2);
        checkOutput("f1_tlast_cnt", 32'(tlastCnt), 32'd1);
        checkOutput("f1_tlast_idx", 32'(lastIdx), 32'd23);
        checkOutput("f1_frame_done", 32'(frameDoneCnt), 32'd1);
        for (int k = 0; k < 24; k++)
            checkOutput("f1_passthru", 32'(k < outLog.size() ? outLog[k] : 16'hDEAD), 32'({8'(k), 8'(k)}));

        $display("[TB] saturation vectors");
        doReset();
        expBias[0] = 8'd50;  expBias[1] = 8'hCE;
        expBias[2] = 8'd127; expBias[3] = 8'h80;
        for (int i = 4; i < 8; i++) expBias[i] = 8'd0;
        loadBiases();
        applyStimulus(8'd100, 8'h9C);
        applyStimulus(8'd1, 8'hFF);
        applyStimulus(8'hFB, 8'd5);
        waitDrain();
`ifdef CONV_BIAS_ACT_RELU_EN
        hand0 = 16'h007F; hand1 = 16'h007F; hand2 = 16'h0500;
`else
        hand0 = 16'h807F; hand1 = 16'h807F; hand2 = 16'h05FB;
`endif
        checkOutput("sat_pos_neg", 32'(outLog.size() > 0 ? outLog[0] : 16'hDEAD), 32'(hand0));
        checkOutput("sat_extreme", 32'(outLog.size() > 1 ? outLog[1] : 16'hDEAD), 32'(hand1));
        checkOutput("no_sat", 32'(outLog.size() > 2 ? outLog[2] : 16'hDEAD), 32'(hand2));

        $display("[TB] random backpressure two frames");
        doReset();
        expBias[0] = 8'd10;  expBias[1] = 8'hEC;
        expBias[2] = 8'd30;  expBias[3] = 8'hD8;
        expBias[4] = 8'd100; expBias[5] = 8'h9C;
        expBias[6] = 8'd5;   expBias[7] = 8'hFB;
        loadBiases();
        randomReady = 1'b1;
        for (int k = 0; k < 48; k++) applyStimulus(8'($urandom), 8'($urandom));
        waitDrain();
        checkOutput("bp_beats", 32'(outBeat), 32'd48);
        checkOutput("bp_tlast_cnt", 32'(tlastCnt), 32'd2);
        checkOutput("bp_tlast_idx", 32'(lastIdx), 32'd47);
        checkOutput("bp_frame_done", 32'(frameDoneCnt), 32'd2);

        $display("[TB] reset mid-frame");
        for (int k = 0; k < 11; k++) applyStimulus(8'(k * 7), 8'(k * 3));
        checkOutput("mid_tvalid_pre", 32'(o_tvalid), 32'd1);
        i_areset = 1'b1;
        @(posedge i_aclk);
        #1;
        checkOutput("mid_tvalid", 32'(o_tvalid), 32'd0);
        checkOutput("mid_tlast", 32'(o_tlast), 32'd0);
        checkOutput("mid_bias_tready", 32'(o_bias_tready), 32'd1);
        checkOutput("mid_tready", 32'(o_tready), 32'd0);
        i_areset = 1'b0;
        for (int i = 0; i < 8; i++) expBias[i] = 8'(i * 3);
        loadBiases();
        for (int k = 0; k < 24; k++) applyStimulus(8'(k + 40), 8'(8'd200 - 8'(k)));
        waitDrain();
        checkOutput("mid_beats", 32'(outBeat), 32'd24);
        checkOutput("mid_tlast_cnt", 32'(tlastCnt), 32'd1);
        checkOutput("mid_tlast_idx", 32'(lastIdx), 32'd23);
        checkOutput("mid_frame_done", 32'(frameDoneCnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
